// File: rtl/fft32_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : fft32_result_streamer
//  Brief    : Snapshots the 32 parallel FFT32 result bins on cycle-done and
//             streams them one bin per beat over valid/ready with |re|+|im|.
//  Revision : 1.0
// ============================================================================
module fft32_result_streamer #(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cycle_done,
    input  logic [WORD_SIZE-1:0] in0_re,
    input  logic [WORD_SIZE-1:0] in1_re,
    input  logic [WORD_SIZE-1:0] in2_re,
    input  logic [WORD_SIZE-1:0] in3_re,
    input  logic [WORD_SIZE-1:0] in4_re,
    input  logic [WORD_SIZE-1:0] in5_re,
    input  logic [WORD_SIZE-1:0] in6_re,
    input  logic [WORD_SIZE-1:0] in7_re,
    input  logic [WORD_SIZE-1:0] in8_re,
    input  logic [WORD_SIZE-1:0] in9_re,
    input  logic [WORD_SIZE-1:0] in10_re,
    input  logic [WORD_SIZE-1:0] in11_re,
    input  logic [WORD_SIZE-1:0] in12_re,
    input  logic [WORD_SIZE-1:0] in13_re,
    input  logic [WORD_SIZE-1:0] in14_re,
    input  logic [WORD_SIZE-1:0] in15_re,
    input  logic [WORD_SIZE-1:0] in16_re,
    input  logic [WORD_SIZE-1:0] in17_re,
    input  logic [WORD_SIZE-1:0] in18_re,
    input  logic [WORD_SIZE-1:0] in19_re,
    input  logic [WORD_SIZE-1:0] in20_re,
    input  logic [WORD_SIZE-1:0] in21_re,
    input  logic [WORD_SIZE-1:0] in22_re,
    input  logic [WORD_SIZE-1:0] in23_re,
    input  logic [WORD_SIZE-1:0] in24_re,
    input  logic [WORD_SIZE-1:0] in25_re,
    input  logic [WORD_SIZE-1:0] in26_re,
    input  logic [WORD_SIZE-1:0] in27_re,
    input  logic [WORD_SIZE-1:0] in28_re,
    input  logic [WORD_SIZE-1:0] in29_re,
    input  logic [WORD_SIZE-1:0] in30_re,
    input  logic [WORD_SIZE-1:0] in31_re,
    input  logic [WORD_SIZE-1:0] in0_im,
    input  logic [WORD_SIZE-1:0] in1_im,
    input  logic [WORD_SIZE-1:0] in2_im,
    input  logic [WORD_SIZE-1:0] in3_im,
    input  logic [WORD_SIZE-1:0] in4_im,
    input  logic [WORD_SIZE-1:0] in5_im,
    input  logic [WORD_SIZE-1:0] in6_im,
    input  logic [WORD_SIZE-1:0] in7_im,
    input  logic [WORD_SIZE-1:0] in8_im,
    input  logic [WORD_SIZE-1:0] in9_im,
    input  logic [WORD_SIZE-1:0] in10_im,
    input  logic [WORD_SIZE-1:0] in11_im,
    input  logic [WORD_SIZE-1:0] in12_im,
    input  logic [WORD_SIZE-1:0] in13_im,
    input  logic [WORD_SIZE-1:0] in14_im,
    input  logic [WORD_SIZE-1:0] in15_im,
    input  logic [WORD_SIZE-1:0] in16_im,
    input  logic [WORD_SIZE-1:0] in17_im,
    input  logic [WORD_SIZE-1:0] in18_im,
    input  logic [WORD_SIZE-1:0] in19_im,
    input  logic [WORD_SIZE-1:0] in20_im,
    input  logic [WORD_SIZE-1:0] in21_im,
    input  logic [WORD_SIZE-1:0] in22_im,
    input  logic [WORD_SIZE-1:0] in23_im,
    input  logic [WORD_SIZE-1:0] in24_im,
    input  logic [WORD_SIZE-1:0] in25_im,
    input  logic [WORD_SIZE-1:0] in26_im,
    input  logic [WORD_SIZE-1:0] in27_im,
    input  logic [WORD_SIZE-1:0] in28_im,
    input  logic [WORD_SIZE-1:0] in29_im,
    input  logic [WORD_SIZE-1:0] in30_im,
    input  logic [WORD_SIZE-1:0] in31_im,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_re,
    output logic [WORD_SIZE-1:0] o_im,
    output logic [WORD_SIZE:0]   o_mag,
    output logic [4:0]           o_index,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int         c_num_bins  = 32;
    localparam logic [4:0] c_last_bin  = 5'd31;

    // FRACTION only documents the Q-format of the bins; it has to fit in a word.
    if (FRACTION < 0 || FRACTION >= WORD_SIZE) begin : g_fraction_range_check
        $error("fft32_result_streamer: FRACTION must lie in [0, WORD_SIZE)");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_done_q;
    logic [4:0]           r_index;
    logic                 r_overrun;
    logic [WORD_SIZE-1:0] r_buf_re [c_num_bins];
    logic [WORD_SIZE-1:0] r_buf_im [c_num_bins];

    logic [WORD_SIZE-1:0] w_in_re [c_num_bins];
    logic [WORD_SIZE-1:0] w_in_im [c_num_bins];
    logic                 w_capture_evt;
    logic                 w_handshake;
    logic                 w_final_hs;
    logic                 w_load;
    logic [WORD_SIZE-1:0] w_cur_re;
    logic [WORD_SIZE-1:0] w_cur_im;
    logic [WORD_SIZE:0]   w_re_abs;
    logic [WORD_SIZE:0]   w_im_abs;

    assign w_in_re[0]  = in0_re;   assign w_in_im[0]  = in0_im;
    assign w_in_re[1]  = in1_re;   assign w_in_im[1]  = in1_im;
    assign w_in_re[2]  = in2_re;   assign w_in_im[2]  = in2_im;
    assign w_in_re[3]  = in3_re;   assign w_in_im[3]  = in3_im;
    assign w_in_re[4]  = in4_re;   assign w_in_im[4]  = in4_im;
    assign w_in_re[5]  = in5_re;   assign w_in_im[5]  = in5_im;
    assign w_in_re[6]  = in6_re;   assign w_in_im[6]  = in6_im;
    assign w_in_re[7]  = in7_re;   assign w_in_im[7]  = in7_im;
    assign w_in_re[8]  = in8_re;   assign w_in_im[8]  = in8_im;
    assign w_in_re[9]  = in9_re;   assign w_in_im[9]  = in9_im;
    assign w_in_re[10] = in10_re;  assign w_in_im[10] = in10_im;
    assign w_in_re[11] = in11_re;  assign w_in_im[11] = in11_im;
    assign w_in_re[12] = in12_re;  assign w_in_im[12] = in12_im;
    assign w_in_re[13] = in13_re;  assign w_in_im[13] = in13_im;
    assign w_in_re[14] = in14_re;  assign w_in_im[14] = in14_im;
    assign w_in_re[15] = in15_re;  assign w_in_im[15] = in15_im;
    assign w_in_re[16] = in16_re;  assign w_in_im[16] = in16_im;
    assign w_in_re[17] = in17_re;  assign w_in_im[17] = in17_im;
    assign w_in_re[18] = in18_re;  assign w_in_im[18] = in18_im;
    assign w_in_re[19] = in19_re;  assign w_in_im[19] = in19_im;
    assign w_in_re[20] = in20_re;  assign w_in_im[20] = in20_im;
    assign w_in_re[21] = in21_re;  assign w_in_im[21] = in21_im;
    assign w_in_re[22] = in22_re;  assign w_in_im[22] = in22_im;
    assign w_in_re[23] = in23_re;  assign w_in_im[23] = in23_im;
    assign w_in_re[24] = in24_re;  assign w_in_im[24] = in24_im;
    assign w_in_re[25] = in25_re;  assign w_in_im[25] = in25_im;
    assign w_in_re[26] = in26_re;  assign w_in_im[26] = in26_im;
    assign w_in_re[27] = in27_re;  assign w_in_im[27] = in27_im;
    assign w_in_re[28] = in28_re;  assign w_in_im[28] = in28_im;
    assign w_in_re[29] = in29_re;  assign w_in_im[29] = in29_im;
    assign w_in_re[30] = in30_re;  assign w_in_im[30] = in30_im;
    assign w_in_re[31] = in31_re;  assign w_in_im[31] = in31_im;

    // A capture is accepted when idle, or when it lands on the final handshake
    // so the next frame follows bin 31 without a gap.
    assign w_capture_evt = i_cycle_done & ~r_done_q;
    assign w_handshake   = (r_state == ST_STREAM) & i_ready;
    assign w_final_hs    = w_handshake & (r_index == c_last_bin);
    assign w_load        = w_capture_evt & ((r_state == ST_IDLE) | w_final_hs);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= ST_IDLE;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done_q <= i_cycle_done;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_valid      = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture_evt) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                if (w_final_hs && !w_capture_evt) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_index   <= 5'd0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load || w_final_hs) begin
                r_index <= 5'd0;
            end else if (w_handshake) begin
                r_index <= r_index + 5'd1;
            end
            if (w_capture_evt && (r_state == ST_STREAM) && !w_final_hs) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < c_num_bins; i++) begin
                r_buf_re[i] <= '0;
                r_buf_im[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < c_num_bins; i++) begin
                r_buf_re[i] <= w_in_re[i];
                r_buf_im[i] <= w_in_im[i];
            end
        end
    end

    // Absolute values are formed one bit wider so the most negative code
    // maps to +2^(WORD_SIZE-1) exactly.
    assign w_cur_re = r_buf_re[r_index];
    assign w_cur_im = r_buf_im[r_index];
    assign w_re_abs = w_cur_re[WORD_SIZE-1] ? ({(WORD_SIZE+1){1'b0}} - {1'b1, w_cur_re})
                                            : {1'b0, w_cur_re};
    assign w_im_abs = w_cur_im[WORD_SIZE-1] ? ({(WORD_SIZE+1){1'b0}} - {1'b1, w_cur_im})
                                            : {1'b0, w_cur_im};

    assign o_re      = w_cur_re;
    assign o_im      = w_cur_im;
    assign o_mag     = w_re_abs + w_im_abs;
    assign o_index   = r_index;
    assign o_last    = o_valid & (r_index == c_last_bin);
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft32_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft32_result_streamer
//  Brief    : Directed self-checking bench for fft32_result_streamer.
//  Revision : 1.0
// ============================================================================
module tb_fft32_result_streamer;

    logic        clk;
    logic        rst;
    logic        cycle_done;
    logic        ready;
    logic [15:0] bin_re [32];
    logic [15:0] bin_im [32];
    logic        valid;
    logic [15:0] re_out;
    logic [15:0] im_out;
    logic [16:0] mag_out;
    logic [4:0]  index_out;
    logic        last_out;
    logic        busy_out;
    logic        overrun_out;

    int checks;
    int errors;

    fft32_result_streamer #(.WORD_SIZE(16), .FRACTION(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_cycle_done(cycle_done),
        .in0_re(bin_re[0]),   .in1_re(bin_re[1]),   .in2_re(bin_re[2]),   .in3_re(bin_re[3]),
        .in4_re(bin_re[4]),   .in5_re(bin_re[5]),   .in6_re(bin_re[6]),   .in7_re(bin_re[7]),
        .in8_re(bin_re[8]),   .in9_re(bin_re[9]),   .in10_re(bin_re[10]), .in11_re(bin_re[11]),
        .in12_re(bin_re[12]), .in13_re(bin_re[13]), .in14_re(bin_re[14]), .in15_re(bin_re[15]),
        .in16_re(bin_re[16]), .in17_re(bin_re[17]), .in18_re(bin_re[18]), .in19_re(bin_re[19]),
        .in20_re(bin_re[20]), .in21_re(bin_re[21]), .in22_re(bin_re[22]), .in23_re(bin_re[23]),
        .in24_re(bin_re[24]), .in25_re(bin_re[25]), .in26_re(bin_re[26]), .in27_re(bin_re[27]),
        .in28_re(bin_re[28]), .in29_re(bin_re[29]), .in30_re(bin_re[30]), .in31_re(bin_re[31]),
        .in0_im(bin_im[0]),   .in1_im(bin_im[1]),   .in2_im(bin_im[2]),   .in3_im(bin_im[3]),
        .in4_im(bin_im[4]),   .in5_im(bin_im[5]),   .in6_im(bin_im[6]),   .in7_im(bin_im[7]),
        .in8_im(bin_im[8]),   .in9_im(bin_im[9]),   .in10_im(bin_im[10]), .in11_im(bin_im[11]),
        .in12_im(bin_im[12]), .in13_im(bin_im[13]), .in14_im(bin_im[14]), .in15_im(bin_im[15]),
        .in16_im(bin_im[16]), .in17_im(bin_im[17]), .in18_im(bin_im[18]), .in19_im(bin_im[19]),
        .in20_im(bin_im[20]), .in21_im(bin_im[21]), .in22_im(bin_im[22]), .in23_im(bin_im[23]),
        .in24_im(bin_im[24]), .in25_im(bin_im[25]), .in26_im(bin_im[26]), .in27_im(bin_im[27]),
        .in28_im(bin_im[28]), .in29_im(bin_im[29]), .in30_im(bin_im[30]), .in31_im(bin_im[31]),
        .o_valid(valid), .i_ready(ready), .o_re(re_out), .o_im(im_out), .o_mag(mag_out),
        .o_index(index_out), .o_last(last_out), .o_busy(busy_out), .o_overrun(overrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat vector: {valid, busy, overrun, index, re, im, mag, last} = 58 bits
    task automatic test_reset();
        logic [57:0] got;
        rst = 1'b0; cycle_done = 1'b0; ready = 1'b0;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'h0; bin_im[k] = 16'h0; end
        @(negedge clk);
        got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
        checks++;
        if (got !== 58'h0) begin
            errors++; $display("FAIL reset_values: got %h expected %h", got, 58'h0);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
        checks++;
        if (got !== 58'h0) begin
            errors++; $display("FAIL idle_after_release: got %h expected %h", got, 58'h0);
        end
    endtask

    task automatic test_basic_frame();
        logic [57:0] got, exp;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'(k * 256); bin_im[k] = 16'(-k); end
        @(negedge clk); cycle_done = 1'b1; ready = 1'b1;
        @(negedge clk); cycle_done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
            exp = {1'b1, 1'b1, 1'b0, 5'(k), 16'(k * 256), 16'(-k), 17'(257 * k), k == 31};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL basic_beat%0d: got %h expected %h", k, got, exp);
            end
            @(negedge clk);
        end
        checks++;
        if ({valid, busy_out, last_out} !== 3'b000) begin
            errors++; $display("FAIL basic_end_idle: got %b expected 000", {valid, busy_out, last_out});
        end
    endtask

    task automatic test_magnitude_corners();
        logic [16:0] exp_mag [4];
        exp_mag[0] = 17'h10000; exp_mag[1] = 17'h00002; exp_mag[2] = 17'h00000; exp_mag[3] = 17'h0FFFF;
        bin_re[0] = 16'h8000; bin_im[0] = 16'h8000;
        bin_re[1] = 16'hFFFF; bin_im[1] = 16'h0001;
        bin_re[2] = 16'h0000; bin_im[2] = 16'h0000;
        bin_re[3] = 16'h7FFF; bin_im[3] = 16'h8000;
        @(negedge clk); cycle_done = 1'b1; ready = 1'b0;
        @(negedge clk); cycle_done = 1'b0;
        @(negedge clk); ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({valid, index_out, mag_out} !== {1'b1, 5'(k), exp_mag[k]}) begin
                errors++;
                $display("FAIL mag_corner%0d: got idx %0d mag %h expected idx %0d mag %h",
                         k, index_out, mag_out, k, exp_mag[k]);
            end
            @(negedge clk);
        end
        repeat (28) @(negedge clk);
        checks++;
        if ({valid, busy_out} !== 2'b00) begin
            errors++; $display("FAIL mag_end_idle: got %b expected 00", {valid, busy_out});
        end
    endtask

    task automatic test_backpressure();
        logic [57:0] got, exp;
        int exp_k;
        int cycles;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'(k); bin_im[k] = 16'(-3 * k); end
        @(negedge clk); cycle_done = 1'b1; ready = 1'b0;
        @(negedge clk); cycle_done = 1'b0;
        exp_k = 0; cycles = 0;
        for (int c = 0; c < 100 && exp_k < 32; c++) begin
            ready = (c % 4 == 0) || (c % 4 == 3);
            got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
            exp = {1'b1, 1'b1, 1'b0, 5'(exp_k), 16'(exp_k), 16'(-3 * exp_k), 17'(4 * exp_k), exp_k == 31};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL bp_cycle%0d: got %h expected %h", c, got, exp);
            end
            if (ready) exp_k++;
            cycles++;
            @(negedge clk);
        end
        ready = 1'b1;
        checks++;
        if (cycles !== 64 || valid !== 1'b0) begin
            errors++; $display("FAIL bp_duration: got %0d cycles valid %b expected 64 cycles valid 0", cycles, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [57:0] got, exp;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'(k + 100); bin_im[k] = 16'(2 * k); end
        @(negedge clk); cycle_done = 1'b1; ready = 1'b1;
        @(negedge clk); cycle_done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
            exp = {1'b1, 1'b1, 1'b0, 5'(k), 16'(k + 100), 16'(2 * k), 17'(3 * k + 100), k == 31};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_a_beat%0d: got %h expected %h", k, got, exp);
            end
            if (k == 31) begin
                cycle_done = 1'b1;
                for (int j = 0; j < 32; j++) begin bin_re[j] = 16'(1000 + j); bin_im[j] = 16'(-(j + 5)); end
            end
            @(negedge clk);
        end
        cycle_done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
            exp = {1'b1, 1'b1, 1'b0, 5'(k), 16'(1000 + k), 16'(-(k + 5)), 17'(1005 + 2 * k), k == 31};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_b_beat%0d: got %h expected %h", k, got, exp);
            end
            @(negedge clk);
        end
        checks++;
        if ({valid, busy_out, overrun_out} !== 3'b000) begin
            errors++; $display("FAIL b2b_end_idle: got %b expected 000", {valid, busy_out, overrun_out});
        end
    endtask

    task automatic test_overrun();
        logic [57:0] got, exp;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'(7 * k); bin_im[k] = 16'(k); end
        @(negedge clk); cycle_done = 1'b1; ready = 1'b1;
        @(negedge clk); cycle_done = 1'b0;
        for (int k = 0; k < 32; k++) begin
            got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
            exp = {1'b1, 1'b1, k >= 11, 5'(k), 16'(7 * k), 16'(k), 17'(8 * k), k == 31};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL ovr_beat%0d: got %h expected %h", k, got, exp);
            end
            if (k == 10) begin
                cycle_done = 1'b1;
                for (int j = 0; j < 32; j++) begin bin_re[j] = 16'hDEAD; bin_im[j] = 16'hBEEF; end
            end
            if (k == 11) cycle_done = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, busy_out, overrun_out} !== 3'b001) begin
            errors++; $display("FAIL ovr_sticky: got %b expected 001", {valid, busy_out, overrun_out});
        end
    endtask

    task automatic test_async_reset();
        logic [57:0] got, exp;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'(3 * k); bin_im[k] = 16'(-5 * k); end
        @(negedge clk); cycle_done = 1'b1; ready = 1'b1;
        @(negedge clk); cycle_done = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k == 17) begin
                checks++;
                if ({valid, index_out, mag_out} !== {1'b1, 5'd17, 17'd136}) begin
                    errors++; $display("FAIL ar_pre_idx17: got idx %0d mag %0d expected idx 17 mag 136", index_out, mag_out);
                end
            end else begin
                @(negedge clk);
            end
        end
        #2 rst = 1'b0;
        #1;
        got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
        checks++;
        if (got !== 58'h0) begin
            errors++; $display("FAIL ar_immediate: got %h expected %h", got, 58'h0);
        end
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 32; k++) begin bin_re[k] = 16'(k + 50); bin_im[k] = 16'(k + 60); end
        @(negedge clk); cycle_done = 1'b1;
        @(negedge clk); cycle_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = {valid, busy_out, overrun_out, index_out, re_out, im_out, mag_out, last_out};
            exp = {1'b1, 1'b1, 1'b0, 5'(k), 16'(k + 50), 16'(k + 60), 17'(2 * k + 110), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL ar_restart_beat%0d: got %h expected %h", k, got, exp);
            end
            @(negedge clk);
        end
        repeat (28) @(negedge clk);
        checks++;
        if ({valid, busy_out} !== 2'b00) begin
            errors++; $display("FAIL ar_end_idle: got %b expected 00", {valid, busy_out});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_frame();
        test_magnitude_corners();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft32_result_streamer.md
# fft32_result_streamer

Output-side consumer for the 32-point FFT core. It detects completion of an FFT32 cycle and snapshots all 32 parallel complex result bins in one clock. It then streams the bins out one per beat over a valid/ready handshake, alongside bin index, L1 magnitude and last-beat marker. It sits between the FFT32 top level and any serial sink (UART framer, FIFO, display logic), so the parallel result bus no longer needs to fan out.

## Interface
Parameters:
- WORD_SIZE, 16, width of each real/imag component, two's complement
- FRACTION, 8, fixed-point fraction bits; pass-through only, no arithmetic depends on it

Ports:
- i_clk  input  1  single clock, rising edge
- i_rst  input  1  asynchronous, active-low reset
- i_cycle_done  input  1  FFT32 cycle-done flag; only its rising edge is used
- in0_re … in31_re  input  WORD_SIZE each  real part of result bins 0..31
- in0_im … in31_im  input  WORD_SIZE each  imaginary part of result bins 0..31
- o_valid  output  1  current beat valid
- i_ready  input  1  sink accepts beat when o_valid & i_ready
- o_re  output  WORD_SIZE  real part of current bin
- o_im  output  WORD_SIZE  imaginary part of current bin
- o_mag  output  WORD_SIZE+1  |re|+|im|, unsigned
- o_index  output  5  bin number of current beat
- o_last  output  1  o_valid & (o_index==31)
- o_busy  output  1  high while a frame is buffered or streaming
- o_overrun  output  1  sticky: a frame was dropped

## Operation
- Edge detect: done_q registers i_cycle_done (reset 0). capture_evt = i_cycle_done & ~done_q. A level already high after reset release counts as an edge.
- Buffer: 32×2 registers of WORD_SIZE. Loaded in full on an accepted capture_evt; otherwise hold.
- FSM, two states:
  - IDLE: o_valid=0, o_busy=0. capture_evt → load buffer, index←0, go STREAM.
  - STREAM: o_valid=1, o_busy=1. o_re/o_im = buffer[index]. Handshake (o_valid & i_ready): if index<31, index←index+1. If index==31, go IDLE, index←0.
- Capture during STREAM: dropped and o_overrun←1, except in the cycle of the final handshake (index==31 & i_ready). That capture is accepted: buffer reloads, index←0, state stays STREAM, no overrun.
- o_overrun clears only on reset.
- Magnitude: abs() of each signed component zero-extended to WORD_SIZE+1, then summed; abs(−2^(WORD_SIZE−1)) = 2^(WORD_SIZE−1) exactly, no saturation. Combinational from buffer[index].
- With i_ready low, o_re/o_im/o_mag/o_index stay stable and o_valid stays high.
- Reset (any time, including mid-frame): state IDLE, index 0, buffer 0, o_overrun 0; the partial frame is discarded.

## Timing
- Reset values: o_valid 0, o_re 0, o_im 0, o_mag 0, o_index 0, o_last 0, o_busy 0, o_overrun 0.
- Capture latency: i_cycle_done first sampled high at edge k → buffer loaded at edge k, o_valid=1 with bin 0 after edge k.
- Throughput: with i_ready held high, 32 consecutive beats, bins 0..31, at one bin per clock.
- Frame duration is 32 cycles plus the number of cycles i_ready is low while o_valid=1.
- Back-to-back frames: bin 31 of frame A and bin 0 of frame B appear on adjacent cycles when the capture coincides with the final handshake.
- Input bins must be stable during the capture cycle only.

## Test plan
- Basic frame: bin k = (re k·256, im −k), pulse done, i_ready=1 → 32 beats on consecutive cycles, o_index 0..31, o_mag=257·k, o_last only at index 31, then o_valid=0, o_busy=0.
- Backpressure: drive i_ready with pattern 1,0,0,1 repeating → every beat appears exactly once in order, outputs stable while i_ready=0, frame lasts 32 accepted beats.
- Overrun: second done rising edge at index 10 → o_overrun=1 and stays 1, frame 1 completes unaltered, o_busy falls after bin 31.
- Back-to-back: second done edge coincides with the final handshake of frame 1 → frame 2 bin 0 on the next cycle, o_overrun=0.
- Magnitude corners: re=16'h8000, im=16'h8000 → o_mag=17'h10000. re=16'hFFFF, im=16'h0001 → o_mag=2. re=0, im=0 → o_mag=0.
- Async reset asserted at index 17 → all outputs reach reset values without waiting for a clock edge. After release and a new done edge, the stream restarts at bin 0 with new data.
